btn_event_decoder: RTL and testbench

BTN_EVENT_DECODER -- requirements
Module: btn_event_decoder

---
 rtl/btn_event_decoder.sv | 125 ++++++++++++
 tb/tb_btn_event_decoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_decoder.sv
// rtl/btn_event_decoder.sv - classifies a debounced button level into press/click/double-click/long-press events
module btn_event_decoder #(
  parameter int CNT_W    = 24,
  parameter int LONG_CYC = 12_000_000,
  parameter int GAP_CYC  = 3_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_db,
  output logic press,
  output logic click,
  output logic dbl_click,
  output logic long_press,
  output logic held
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HELD   = 3'd4
  } state_t;

  // Terminal counts are one less than the interval because cnt starts at 0 on state entry.
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;
  logic             press_q, press_d;
  logic             click_q, click_d;
  logic             dbl_click_q, dbl_click_d;
  logic             long_press_q, long_press_d;
  logic             held_q, held_d;
  logic             rise, fall;

  assign rise = btn_db & ~btn_q;
  assign fall = ~btn_db & btn_q;

  // Next-state, interval counter and registered event outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    btn_d        = btn_db;
    press_d      = rise;
    click_d      = 1'b0;
    dbl_click_d  = 1'b0;
    long_press_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          state_d = WAIT2;
        end else if (cnt_q == LONG_TC) begin
          state_d      = HELD;
          long_press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT2: begin
        if (rise) begin
          state_d = PRESS2;
        end else if (cnt_q == GAP_TC) begin
          state_d = IDLE;
          click_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_d     = IDLE;
          dbl_click_d = 1'b1;
        end else if (cnt_q == LONG_TC) begin
          state_d      = HELD;
          long_press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Every transition restarts the interval measurement.
    if (state_d != state_q) cnt_d = '0;
    held_d = (state_d == HELD);
  end

  // State, counter, input sample and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      btn_q        <= 1'b0;
      press_q      <= 1'b0;
      click_q      <= 1'b0;
      dbl_click_q  <= 1'b0;
      long_press_q <= 1'b0;
      held_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      btn_q        <= btn_d;
      press_q      <= press_d;
      click_q      <= click_d;
      dbl_click_q  <= dbl_click_d;
      long_press_q <= long_press_d;
      held_q       <= held_d;
    end
  end

  assign press      = press_q;
  assign click      = click_q;
  assign dbl_click  = dbl_click_q;
  assign long_press = long_press_q;
  assign held       = held_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb/tb_btn_event_decoder.sv - directed and random checks for btn_event_decoder
module tb_btn_event_decoder;

  logic clk;
  logic rst_n;
  logic btn_db;
  logic press, click, dbl_click, long_press, held;

  int n_tests;
  int n_fail;

  // Output vector order: {press, click, dbl_click, long_press, held}
  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] P  = 5'b10000;
  localparam logic [4:0] C  = 5'b01000;
  localparam logic [4:0] D  = 5'b00100;
  localparam logic [4:0] LH = 5'b00011;
  localparam logic [4:0] H  = 5'b00001;

  btn_event_decoder #(
    .CNT_W   (4),
    .LONG_CYC(8),
    .GAP_CYC (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_db    (btn_db),
    .press     (press),
    .click     (click),
    .dbl_click (dbl_click),
    .long_press(long_press),
    .held      (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one input level, then sample just after the edge that consumed it.
  task automatic cyc(input logic b);
    btn_db = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk5(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {press, click, dbl_click, long_press, held};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic       level;
    logic       prev;
    logic       rise_m;
    logic [3:0] prev_pulses;
    logic [3:0] cur_pulses;
    int         n_rise;
    int         n_press;
    int         len;

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    btn_db  = 1'b0;
    @(posedge clk);
    #1;
    chk5("reset_state", Z);
    rst_n = 1'b1;
    cyc(0); cyc(0);
    chk5("idle", Z);

    // Single click: high 3, then low; click 4 edges after WAIT2 entry.
    cyc(1); chk5("sc_press", P);
    cyc(1); chk5("sc_p1a", Z);
    cyc(1); chk5("sc_p1b", Z);
    cyc(0); chk5("sc_w0", Z);
    cyc(0); chk5("sc_w1", Z);
    cyc(0); chk5("sc_w2", Z);
    cyc(0); chk5("sc_w3", Z);
    cyc(0); chk5("sc_click", C);
    cyc(0); chk5("sc_after", Z);

    // Double click: high 2, low 2, high 2, low.
    cyc(1); chk5("dc_press1", P);
    cyc(1); chk5("dc_p1", Z);
    cyc(0); chk5("dc_w0", Z);
    cyc(0); chk5("dc_w1", Z);
    cyc(1); chk5("dc_press2", P);
    cyc(1); chk5("dc_p2", Z);
    cyc(0); chk5("dc_dbl", D);
    for (int i = 0; i < 6; i++) begin
      cyc(0); chk5("dc_no_click", Z);
    end

    // Long press: high 12 cycles.
    cyc(1); chk5("lp_press", P);
    for (int i = 0; i < 7; i++) begin
      cyc(1); chk5("lp_count", Z);
    end
    cyc(1); chk5("lp_long", LH);
    for (int i = 0; i < 3; i++) begin
      cyc(1); chk5("lp_held", H);
    end
    cyc(0); chk5("lp_release", Z);
    for (int i = 0; i < 5; i++) begin
      cyc(0); chk5("lp_no_click", Z);
    end

    // Fall coincides with cnt==7 in PRESS1; then an exact 4-cycle gap gives click.
    cyc(1); chk5("b1_press", P);
    for (int i = 0; i < 7; i++) begin
      cyc(1); chk5("b1_count", Z);
    end
    cyc(0); chk5("b1_fall_at_tc", Z);
    cyc(0); chk5("b1_w1", Z);
    cyc(0); chk5("b1_w2", Z);
    cyc(0); chk5("b1_w3", Z);
    cyc(0); chk5("b1_click", C);
    cyc(1); chk5("b1_new_press", P);
    cyc(0); chk5("b1_new_w0", Z);
    cyc(0); chk5("b1_new_w1", Z);
    cyc(0); chk5("b1_new_w2", Z);
    cyc(0); chk5("b1_new_w3", Z);
    cyc(0); chk5("b1_new_click", C);

    // Rise coinciding with the gap terminal count wins: double click, no click.
    cyc(1); chk5("b2_press1", P);
    cyc(1); chk5("b2_p1", Z);
    cyc(0); chk5("b2_w0", Z);
    cyc(0); chk5("b2_w1", Z);
    cyc(0); chk5("b2_w2", Z);
    cyc(0); chk5("b2_w3", Z);
    cyc(1); chk5("b2_press2", P);
    cyc(0); chk5("b2_dbl", D);
    cyc(0); chk5("b2_after", Z);

    // Asynchronous reset clears a live press pulse; btn high through release gives a new press.
    cyc(1); chk5("rs_press", P);
    rst_n = 1'b0;
    #1;
    chk5("rs_async_clear", Z);
    rst_n = 1'b1;
    cyc(1); chk5("rs_rise_after_release", P);
    cyc(0); chk5("rs_w0", Z);
    cyc(0); chk5("rs_w1", Z);
    btn_db = 1'b1;
    rst_n  = 1'b0;
    #1;
    chk5("rs_wait2_async", Z);
    for (int i = 0; i < 5; i++) begin
      cyc(1); chk5("rs_held_low", Z);
    end
    rst_n = 1'b1;
    cyc(1); chk5("rs_release_press", P);
    cyc(0); chk5("rs_n_w0", Z);
    cyc(0); chk5("rs_n_w1", Z);
    cyc(0); chk5("rs_n_w2", Z);
    cyc(0); chk5("rs_n_w3", Z);
    cyc(0); chk5("rs_n_click", C);

    // Random run-length stream with scoreboard invariants.
    prev        = btn_db;
    level       = btn_db;
    n_rise      = 0;
    n_press     = 0;
    prev_pulses = 4'b0000;
    for (int r = 0; r < 60; r++) begin
      level = ~level;
      len   = int'($urandom_range(1, 11));
      for (int k = 0; k < len; k++) begin
        cyc(level);
        rise_m = level & ~prev;
        prev   = level;
        if (rise_m) n_rise++;
        if (press === 1'b1) n_press++;
        cur_pulses = {press, click, dbl_click, long_press};
        chk1("rnd_press_vs_rise", press, rise_m);
        chk1("rnd_one_event", ($countones(cur_pulses[2:0]) <= 1), 1'b1);
        chk1("rnd_pulse_width", ((prev_pulses & cur_pulses) == 4'b0000), 1'b1);
        prev_pulses = cur_pulses;
      end
    end
    n_tests++;
    assert (n_press == n_rise) else begin
      n_fail++;
      $error("FAIL rnd_press_count observed=%0d expected=%0d", n_press, n_rise);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
